// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch/watch UART command path.
// ASCII command bytes and the TX arbiter state encoding.
package stopwatch_pkg;

  localparam logic [7:0] CMD_RUN      = 8'h72;
  localparam logic [7:0] CMD_CLR      = 8'h6C;
  localparam logic [7:0] CMD_UP       = 8'h75;
  localparam logic [7:0] CMD_DN       = 8'h64;
  localparam logic [7:0] CMD_SW0      = 8'h30;
  localparam logic [7:0] CMD_ERR_ECHO = 8'h3F;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_WAIT_BUSY,
    ARB_WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX core between
// the command echo and the sensor report requester.
module uart_tx_arb
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       echo_req,
  input  logic [7:0] echo_data,
  input  logic       rpt_req,
  input  logic [7:0] rpt_data,
  input  logic       tx_busy,
  output logic       echo_take,
  output logic       rpt_gnt,
  output logic       tx_start,
  output logic [7:0] tx_data
);

  arb_state_e state, state_n;
  logic       sel_rpt, sel_rpt_n;
  logic       last_echo, last_echo_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      sel_rpt   <= 1'b0;
      last_echo <= 1'b0;
    end else begin
      state     <= state_n;
      sel_rpt   <= sel_rpt_n;
      last_echo <= last_echo_n;
    end
  end

  always_comb begin
    state_n     = state;
    sel_rpt_n   = sel_rpt;
    last_echo_n = last_echo;
    echo_take   = 1'b0;
    rpt_gnt     = 1'b0;
    tx_start    = 1'b0;
    tx_data     = 8'h00;
    unique case (state)
      ARB_IDLE: begin
        if (!tx_busy && (echo_req || rpt_req)) begin
          state_n   = ARB_START;
          sel_rpt_n = rpt_req && (!echo_req || last_echo);
        end
      end
      ARB_START: begin
        // A report withdrawn before its grant is simply skipped
        if (sel_rpt) begin
          if (rpt_req) begin
            rpt_gnt     = 1'b1;
            tx_start    = 1'b1;
            tx_data     = rpt_data;
            last_echo_n = 1'b0;
            state_n     = ARB_WAIT_BUSY;
          end else begin
            state_n = ARB_IDLE;
          end
        end else begin
          echo_take   = 1'b1;
          tx_start    = 1'b1;
          tx_data     = echo_data;
          last_echo_n = 1'b1;
          state_n     = ARB_WAIT_BUSY;
        end
      end
      ARB_WAIT_BUSY: begin
        if (tx_busy) state_n = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        if (!tx_busy) state_n = ARB_IDLE;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command decoder: button pulses, switch toggles and a
// one-entry echo register feeding the shared TX arbiter.
module uart_cmd_ctrl
  import stopwatch_pkg::*;
#(
  parameter int SW_N = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_done,
  input  logic [SW_N-1:0] sw_phys,
  output logic [SW_N-1:0] sw_out,
  output logic            btn_r_pulse,
  output logic            btn_l_pulse,
  output logic            btn_u_pulse,
  output logic            btn_d_pulse,
  output logic            cmd_err,
  output logic            echo_ovf,
  input  logic            rpt_req,
  input  logic [7:0]      rpt_data,
  output logic            rpt_gnt,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_busy
);

  logic [SW_N-1:0] sw_tgl;
  logic [SW_N-1:0] tgl_mask;
  logic            is_sw;
  logic            p_r, p_l, p_u, p_d, p_err;
  logic [7:0]      echo_val;
  logic            echo_pend;
  logic [7:0]      echo_byte;
  logic            echo_take;
  logic            echo_full;

  always_comb begin
    for (int k = 0; k < SW_N; k++)
      tgl_mask[k] = (rx_data == CMD_SW0 + 8'(k));
  end

  assign is_sw = |tgl_mask;

  always_comb begin
    p_r      = 1'b0;
    p_l      = 1'b0;
    p_u      = 1'b0;
    p_d      = 1'b0;
    p_err    = 1'b0;
    echo_val = rx_data;
    unique case (1'b1)
      rx_data == CMD_RUN: p_r = 1'b1;
      rx_data == CMD_CLR: p_l = 1'b1;
      rx_data == CMD_UP:  p_u = 1'b1;
      rx_data == CMD_DN:  p_d = 1'b1;
      is_sw:              echo_val = rx_data;
      default: begin
        p_err    = 1'b1;
        echo_val = CMD_ERR_ECHO;
      end
    endcase
  end

  // A slot freed by the arbiter this cycle may be refilled at once
  assign echo_full = echo_pend && !echo_take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_r_pulse <= 1'b0;
      btn_l_pulse <= 1'b0;
      btn_u_pulse <= 1'b0;
      btn_d_pulse <= 1'b0;
      cmd_err     <= 1'b0;
      echo_ovf    <= 1'b0;
      sw_tgl      <= '0;
      echo_pend   <= 1'b0;
      echo_byte   <= 8'h00;
    end else begin
      btn_r_pulse <= rx_done && p_r;
      btn_l_pulse <= rx_done && p_l;
      btn_u_pulse <= rx_done && p_u;
      btn_d_pulse <= rx_done && p_d;
      cmd_err     <= rx_done && p_err;
      echo_ovf    <= rx_done && echo_full;
      if (rx_done)
        sw_tgl <= sw_tgl ^ tgl_mask;
      if (rx_done && !echo_full) begin
        echo_pend <= 1'b1;
        echo_byte <= echo_val;
      end else if (echo_take) begin
        echo_pend <= 1'b0;
      end
    end
  end

  assign sw_out = sw_phys ^ sw_tgl;

  uart_tx_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .echo_req  (echo_pend),
    .echo_data (echo_byte),
    .rpt_req   (rpt_req),
    .rpt_data  (rpt_data),
    .tx_busy   (tx_busy),
    .echo_take (echo_take),
    .rpt_gnt   (rpt_gnt),
    .tx_start  (tx_start),
    .tx_data   (tx_data)
  );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl with a simple TX core model.
// Stimulus pushes expected pulses and TX bytes; a monitor pops them.
module tb_uart_cmd_ctrl;

  localparam int SW_N = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_done = 1'b0;
  logic [SW_N-1:0] sw_phys = '0;
  logic [SW_N-1:0] sw_out;
  logic            btn_r_pulse, btn_l_pulse;
  logic            btn_u_pulse, btn_d_pulse;
  logic            cmd_err, echo_ovf;
  logic            rpt_req = 1'b0;
  logic [7:0]      rpt_data = 8'h00;
  logic            rpt_gnt, tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            force_busy = 1'b0;
  logic            m_busy;
  int              m_cnt;

  int checks = 0;
  int fails = 0;
  int tx_seen = 0;

  logic [5:0] pq[$];
  logic [8:0] tq[$];
  logic [5:0] ev_now;

  localparam logic [5:0] EV_R   = 6'b100000;
  localparam logic [5:0] EV_L   = 6'b010000;
  localparam logic [5:0] EV_U   = 6'b001000;
  localparam logic [5:0] EV_D   = 6'b000100;
  localparam logic [5:0] EV_ERR = 6'b000010;
  localparam logic [5:0] EV_OVF = 6'b000001;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.SW_N(SW_N)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .sw_phys     (sw_phys),
    .sw_out      (sw_out),
    .btn_r_pulse (btn_r_pulse),
    .btn_l_pulse (btn_l_pulse),
    .btn_u_pulse (btn_u_pulse),
    .btn_d_pulse (btn_d_pulse),
    .cmd_err     (cmd_err),
    .echo_ovf    (echo_ovf),
    .rpt_req     (rpt_req),
    .rpt_data    (rpt_data),
    .rpt_gnt     (rpt_gnt),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy)
  );

  assign ev_now = {btn_r_pulse, btn_l_pulse, btn_u_pulse,
                   btn_d_pulse, cmd_err, echo_ovf};
  assign tx_busy = m_busy | force_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (tx_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 5;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
    end
  end

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ev_now != 6'b0) begin
        if (pq.size() == 0) chk("pulse_unexpected", 32'(ev_now), 0);
        else chk("pulse", 32'(ev_now), 32'(pq.pop_front()));
      end
      if (tx_start) begin
        tx_seen++;
        chk("tx_while_busy", 32'(tx_busy), 0);
        if (tq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL tx_unexpected: got gnt=%0b data=%0h expected none",
                   rpt_gnt, tx_data);
        end else begin
          chk("tx", 32'({rpt_gnt, tx_data}), 32'(tq.pop_front()));
        end
      end
      if (rpt_gnt && !tx_start) begin
        checks++;
        fails++;
        $display("FAIL gnt_no_start: got gnt=1 start=0 expected start=1");
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 300 && (tq.size() != 0 || pq.size() != 0 ||
                       tx_busy || tx_start)) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < 300), 1);
    repeat (3) step();
  endtask

  task automatic tie(logic [7:0] b, logic [5:0] ev,
                     logic [7:0] rd, logic rpt_first);
    int n;
    pq.push_back(ev);
    if (rpt_first) begin
      tq.push_back({1'b1, rd});
      tq.push_back({1'b0, b});
    end else begin
      tq.push_back({1'b0, b});
      tq.push_back({1'b1, rd});
    end
    send(b);
    rpt_req  = 1'b1;
    rpt_data = rd;
    n = 0;
    while (n < 200 && !rpt_gnt) begin
      step();
      n++;
    end
    chk("gnt_timeout", 32'(rpt_gnt), 1);
    step();
    rpt_req = 1'b0;
    drain();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    sw_phys = 5'b10100;
    repeat (3) step();
    chk("rst_sw_out", 32'(sw_out), 32'(5'b10100));
    chk("rst_pulses", 32'(ev_now), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_gnt", 32'(rpt_gnt), 0);
    rst_n = 1'b1;
    sw_phys = 5'b00000;
    repeat (2) step();

    // ties right after reset: echo first both times
    tie(8'h75, EV_U, 8'h55, 1'b0);
    tie(8'h64, EV_D, 8'hA5, 1'b0);

    // run command twice, timing at n+1 and n+2
    for (int i = 0; i < 2; i++) begin
      pq.push_back(EV_R);
      tq.push_back({1'b0, 8'h72});
      send(8'h72);
      chk("r_pulse_n1", 32'(btn_r_pulse), 1);
      step();
      chk("tx_start_n2", 32'(tx_start), 1);
      drain();
    end

    // switch toggles
    pq.push_back(6'b0);
    pq.delete();
    tq.push_back({1'b0, 8'h30});
    send(8'h30);
    chk("sw_a", 32'(sw_out), 32'(5'b00001));
    drain();
    tq.push_back({1'b0, 8'h31});
    send(8'h31);
    chk("sw_b", 32'(sw_out), 32'(5'b00011));
    drain();
    tq.push_back({1'b0, 8'h32});
    send(8'h32);
    chk("sw_c", 32'(sw_out), 32'(5'b00111));
    drain();
    tq.push_back({1'b0, 8'h31});
    send(8'h31);
    chk("sw_d", 32'(sw_out), 32'(5'b00101));
    drain();

    // uppercase is an error
    pq.push_back(EV_ERR);
    tq.push_back({1'b0, 8'h3F});
    send(8'h41);
    chk("err_pulse", 32'(cmd_err), 1);
    chk("err_sw", 32'(sw_out), 32'(5'b00101));
    drain();

    // last served was echo: the report wins this tie
    tie(8'h75, EV_U, 8'h5A, 1'b1);

    // two commands while TX busy: second echo dropped
    force_busy = 1'b1;
    pq.push_back(EV_D);
    pq.push_back(EV_L | EV_OVF);
    tq.push_back({1'b0, 8'h64});
    rx_data = 8'h64;
    rx_done = 1'b1;
    step();
    rx_data = 8'h6C;
    step();
    rx_done = 1'b0;
    repeat (5) step();
    force_busy = 1'b0;
    drain();

    // reset in WAIT_DONE with toggles set and an echo pending
    sw_phys = 5'b01010;
    step();
    chk("sw_pre_rst", 32'(sw_out), 32'(5'b01111));
    pq.push_back(EV_R);
    tq.push_back({1'b0, 8'h72});
    send(8'h72);
    base = 0;
    while (base < 50 && !(tx_busy && tq.size() == 0)) begin
      step();
      base++;
    end
    chk("busy_timeout", 32'(tx_busy), 1);
    step();
    pq.push_back(EV_U);
    send(8'h75);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sw", 32'(sw_out), 32'(5'b01010));
    chk("mid_rst_pulses", 32'(ev_now), 0);
    chk("mid_rst_tx_start", 32'(tx_start), 0);
    chk("mid_rst_tx_data", 32'(tx_data), 0);
    step();
    step();
    rst_n = 1'b1;
    base = tx_seen;
    repeat (30) step();
    chk("no_tx_after_rst", 32'(tx_seen - base), 0);

    pq.push_back(EV_L);
    tq.push_back({1'b0, 8'h6C});
    send(8'h6C);
    drain();
    tq.push_back({1'b0, 8'h33});
    send(8'h33);
    chk("sw_post_rst", 32'(sw_out), 32'(5'b00010));
    drain();

    chk("pq_empty", 32'(pq.size()), 0);
    chk("tq_empty", 32'(tq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

- Turns bytes received from the UART RX core into control events for the stopwatch/watch top level:
  - one-cycle run/stop, clear, up and down button pulses;
  - persistent switch toggles.
- Arbitrates the single UART TX core between command echoes and an external report requester (the sensor report path for DHT and ultrasonic data).
- Sits between `uart_rx`/`uart_tx` and the stopwatch, watch and sensor control logic in `stopwatch_watch`.

## Interface
Parameters:
- `SW_N`, 5, number of switches that can be toggled over UART (`'0'`..`'0'+SW_N-1`).

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid when `rx_done` = 1.
- `rx_done`  in  1  one-cycle strobe from the RX core.
- `sw_phys`  in  SW_N  physical board switches.
- `sw_out`  out  SW_N  effective switches; `sw_phys ^ sw_tgl`.
- `btn_r_pulse`, `btn_l_pulse`, `btn_u_pulse`, `btn_d_pulse`  out  1 each  one-cycle command pulses.
- `cmd_err`  out  1  one-cycle pulse when an unrecognised byte is received.
- `echo_ovf`  out  1  one-cycle pulse when an echo is dropped.
- `rpt_req`  in  1  report requester has a byte to send; level signal, held until granted.
- `rpt_data`  in  8  report byte; sampled in the cycle `rpt_gnt` = 1.
- `rpt_gnt`  out  1  one-cycle grant; the report byte is taken.
- `tx_start`  out  1  one-cycle start to the TX core.
- `tx_data`  out  8  byte to transmit; valid with `tx_start`.
- `tx_busy`  in  1  TX core busy.

## Operation
Command decode (registered; `rx_byte` is captured on `rx_done`):
- `0x72` `'r'` → `btn_r_pulse`.
- `0x6C` `'l'` → `btn_l_pulse`.
- `0x75` `'u'` → `btn_u_pulse`.
- `0x64` `'d'` → `btn_d_pulse`.
- `0x30+k` with k < `SW_N` → `sw_tgl[k]` inverted.
- Any other byte → `cmd_err` pulse. Uppercase letters are errors.

Echo handling:
- Every received byte sets a 1-entry echo register:
  - recognised command: the echo byte is the received byte;
  - error: the echo byte is `0x3F` (`'?'`).
- If the echo register is already pending when a new byte decodes:
  - the new command still executes;
  - the new echo is dropped;
  - `echo_ovf` pulses.

TX arbiter FSM, states IDLE, START, WAIT_BUSY, WAIT_DONE:
- IDLE → START when `tx_busy` = 0 and (echo pending or `rpt_req`).
  - If both are pending, round-robin on a `last_was_echo` flag: grant the one not served last.
- START: `tx_start` = 1 and `tx_data` = the selected byte for exactly one cycle.
  - Report selected: `rpt_gnt` = 1 in the same cycle.
  - Echo selected: echo pending clears.
  - Next state is WAIT_BUSY.
- WAIT_BUSY → WAIT_DONE on `tx_busy` = 1.
- WAIT_DONE → IDLE on `tx_busy` = 0.

Outputs and state after reset:
- All pulses = 0.
- `tx_start` = 0, `tx_data` = 0x00.
- `sw_tgl` = 0, so `sw_out` = `sw_phys`.
- FSM = IDLE, echo not pending.
- `last_was_echo` = 0, so echo wins the first tie.

## Timing
- `rx_done` at cycle n:
  - decode pulse, `cmd_err` and `sw_out` change at cycle n+1;
  - echo pending from n+1;
  - earliest `tx_start` at n+2.
- `sw_out` is combinational on `sw_phys` and registered `sw_tgl`.
- Pulses are exactly one cycle wide; back-to-back `rx_done` strobes give back-to-back pulses.
- The echo-pending clear in START and a new echo set in the same cycle → the set wins, and no overflow is flagged.
- `rpt_req` deasserted before grant → no grant is issued; no abort is needed.
- `reset` asserted mid-transfer:
  - the FSM returns to IDLE immediately;
  - a pending echo or report is discarded;
  - the TX core handles its own reset.
- Latency from `rpt_req` (IDLE, no echo) to `rpt_gnt` and `tx_start`: 1 cycle.

## Structure
- Shared package `stopwatch_pkg`:
  - ASCII constants `CMD_RUN` (0x72), `CMD_CLR` (0x6C), `CMD_UP` (0x75), `CMD_DN` (0x64), `CMD_SW0` (0x30), `CMD_ERR_ECHO` (0x3F);
  - the arbiter state encoding.
- One sub-module, `uart_tx_arb`: two requesters, round-robin, START/WAIT_BUSY/WAIT_DONE handshake with the TX core.
- Decode and toggle registers live in `uart_cmd_ctrl`.

## Test plan
- Send `0x72` then `0x72` via `rx_done` → two single-cycle `btn_r_pulse` at n+1; `tx_data` = 0x72 echoed twice; `tx_start` only while `tx_busy` = 0.
- Send `0x30`, `0x31`, `0x32` with `sw_phys` = 5'b00000 → `sw_out` = 5'b00111; send `0x31` again → `sw_out` = 5'b00101.
- Send `0x41` → `cmd_err` pulse; echo `tx_data` = 0x3F; `sw_out` and the button pulses unchanged.
- Hold `rpt_req` = 1 with `rpt_data` = 0x55 while echo `0x75` is pending from reset → order is echo 0x75, then report 0x55 with `rpt_gnt`; the next tie goes to echo.
- Two `rx_done` strobes (`0x64`, `0x6C`) while the TX core is busy → both pulses fire; `echo_ovf` on the second; only 0x64 is echoed.
- Assert `reset` low during WAIT_DONE with `sw_tgl` ≠ 0 → all outputs reach reset values the same cycle; `sw_out` = `sw_phys`; no `tx_start` after release until a new request arrives.
